// File: rtl/instr_decode_stage_if.sv
// Handshake bundle for the instruction decode stage: fetch-side valid/ready
// with instruction word and PC, EX-side valid/ready with the decoded fields.
// The stage itself connects through the slave modport.
interface instr_decode_stage_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [PC_W-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [3:0]       alu_op;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [4:0]       dest_reg;
    logic             reg_write;
    logic             use_imm;
    logic             use_sa;
    logic [4:0]       shamt;
    logic [31:0]      imm_ext;
    logic             is_store;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, instruction, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, alu_op, rs_addr, rt_addr, dest_reg,
               reg_write, use_imm, use_sa, shamt, imm_ext, is_store, illegal,
               illegal_cnt
    );

    modport slave (
        input  in_valid, instruction, in_pc, out_ready,
        output in_ready, out_valid, out_pc, alu_op, rs_addr, rt_addr, dest_reg,
               reg_write, use_imm, use_sa, shamt, imm_ext, is_store, illegal,
               illegal_cnt
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Instruction decode (ID) stage. Each incoming word is decoded combinationally
// on entry and stored already decoded, either straight into the output
// register or into a one-entry skid register when EX stalls. Both sides use
// valid/ready; IN_READY is registered and drops only when both entries hold
// data. FLUSH empties the stage and drops the word presented that cycle.
module instr_decode_stage #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    instr_decode_stage_if.slave bus
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDI  = 6'h01,
        OP_SUBI  = 6'h02,
        OP_ANDI  = 6'h03,
        OP_ORI   = 6'h04,
        OP_XORI  = 6'h05,
        OP_LUI   = 6'h06,
        OP_LLI   = 6'h07,
        OP_SWR   = 6'h08
    } opcode_t;

    typedef enum logic [5:0] {
        FN_ADD = 6'h01,
        FN_SUB = 6'h02,
        FN_AND = 6'h03,
        FN_OR  = 6'h04,
        FN_XOR = 6'h05,
        FN_SLL = 6'h06,
        FN_SRL = 6'h07,
        FN_SLA = 6'h08,
        FN_SRA = 6'h09
    } func_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SLA = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;
    localparam logic [3:0] ALU_LLI = 4'd10;
    localparam logic [3:0] ALU_NOP = 4'd15;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic [4:0]      rs_addr;
        logic [4:0]      rt_addr;
        logic [4:0]      dest_reg;
        logic            reg_write;
        logic            use_imm;
        logic            use_sa;
        logic [4:0]      shamt;
        logic [31:0]     imm_ext;
        logic            is_store;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } bundle_t;

    // Idle bundle: NOP opcode, every other field cleared.
    function automatic bundle_t nop_bundle();
        bundle_t b;
        b        = '0;
        b.alu_op = ALU_NOP;
        return b;
    endfunction

    // Full decode of one instruction word into the EX control bundle.
    function automatic bundle_t decode(input logic [31:0] w, input logic [PC_W-1:0] pc);
        bundle_t     b;
        opcode_t     op;
        logic        writes;
        logic [31:0] sext;
        logic [31:0] zext;
        op        = opcode_t'(w[31:26]);
        sext      = {{16{w[15]}}, w[15:0]};
        zext      = {16'h0000, w[15:0]};
        writes    = 1'b0;
        b         = nop_bundle();
        b.rs_addr = w[25:21];
        b.rt_addr = w[20:16];
        b.shamt   = w[10:6];
        b.pc      = pc;
        if (w == 32'h0000_0000) begin
            b.alu_op = ALU_NOP;
        end else begin
            case (op)
                OP_RTYPE: begin
                    b.dest_reg = w[15:11];
                    writes     = 1'b1;
                    case (func_t'(w[5:0]))
                        FN_ADD:  b.alu_op = ALU_ADD;
                        FN_SUB:  b.alu_op = ALU_SUB;
                        FN_AND:  b.alu_op = ALU_AND;
                        FN_OR:   b.alu_op = ALU_OR;
                        FN_XOR:  b.alu_op = ALU_XOR;
                        FN_SLL:  begin b.alu_op = ALU_SLL; b.use_sa = 1'b1; end
                        FN_SRL:  begin b.alu_op = ALU_SRL; b.use_sa = 1'b1; end
                        FN_SLA:  begin b.alu_op = ALU_SLA; b.use_sa = 1'b1; end
                        FN_SRA:  begin b.alu_op = ALU_SRA; b.use_sa = 1'b1; end
                        default: begin
                            b.illegal  = 1'b1;
                            b.dest_reg = 5'd0;
                            writes     = 1'b0;
                        end
                    endcase
                end
                OP_ADDI: begin b.alu_op = ALU_ADD; b.imm_ext = sext; end
                OP_SUBI: begin b.alu_op = ALU_SUB; b.imm_ext = sext; end
                OP_ANDI: begin b.alu_op = ALU_AND; b.imm_ext = zext; end
                OP_ORI:  begin b.alu_op = ALU_OR;  b.imm_ext = zext; end
                OP_XORI: begin b.alu_op = ALU_XOR; b.imm_ext = zext; end
                OP_LUI:  begin b.alu_op = ALU_LUI; b.imm_ext = {w[15:0], 16'h0000}; end
                OP_LLI:  begin b.alu_op = ALU_LLI; b.imm_ext = zext; end
                OP_SWR: begin
                    b.alu_op   = ALU_ADD;
                    b.imm_ext  = sext;
                    b.use_imm  = 1'b1;
                    b.is_store = 1'b1;
                end
                default: b.illegal = 1'b1;
            endcase
            // Immediate ALU forms share operand selection and write RT.
            if ((op != OP_RTYPE) && (op != OP_SWR) && !b.illegal) begin
                b.use_imm  = 1'b1;
                b.dest_reg = w[20:16];
                writes     = 1'b1;
            end else begin
                b.use_imm  = b.use_imm;
            end
        end
        b.reg_write = writes && (b.dest_reg != 5'd0);
        return b;
    endfunction

    state_t  state_r;
    logic    in_ready_r;
    logic    out_valid_r;
    bundle_t out_r;
    bundle_t skid_r;
    bundle_t dec_s;
    logic    in_fire_s;
    logic    out_fire_s;
    logic [CNT_W-1:0] cnt_r;

    // Decode the word currently presented by fetch.
    always_comb begin
        dec_s = decode(bus.instruction, bus.in_pc);
    end

    assign in_fire_s  = bus.in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & bus.out_ready;

    // Handshake FSM, output/skid registers and saturating illegal counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= nop_bundle();
            skid_r      <= nop_bundle();
            cnt_r       <= '0;
        end else begin
            if (!flush && out_fire_s && out_r.illegal && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (flush) begin
                state_r     <= ST_EMPTY;
                in_ready_r  <= 1'b1;
                out_valid_r <= 1'b0;
                out_r       <= nop_bundle();
                skid_r      <= nop_bundle();
            end else begin
                case (state_r)
                    ST_EMPTY: begin
                        if (in_fire_s) begin
                            out_r       <= dec_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        case ({in_fire_s, out_fire_s})
                            2'b10: begin
                                skid_r     <= dec_s;
                                in_ready_r <= 1'b0;
                                state_r    <= ST_FULL;
                            end
                            2'b01: begin
                                out_valid_r <= 1'b0;
                                state_r     <= ST_EMPTY;
                            end
                            2'b11: begin
                                out_r <= dec_s;
                            end
                            default: begin
                                state_r <= ST_ONE;
                            end
                        endcase
                    end
                    ST_FULL: begin
                        if (out_fire_s) begin
                            out_r      <= skid_r;
                            in_ready_r <= 1'b1;
                            state_r    <= ST_ONE;
                        end
                    end
                    default: begin
                        state_r     <= ST_EMPTY;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_pc      = out_r.pc;
    assign bus.alu_op      = out_r.alu_op;
    assign bus.rs_addr     = out_r.rs_addr;
    assign bus.rt_addr     = out_r.rt_addr;
    assign bus.dest_reg    = out_r.dest_reg;
    assign bus.reg_write   = out_r.reg_write;
    assign bus.use_imm     = out_r.use_imm;
    assign bus.use_sa      = out_r.use_sa;
    assign bus.shamt       = out_r.shamt;
    assign bus.imm_ext     = out_r.imm_ext;
    assign bus.is_store    = out_r.is_store;
    assign bus.illegal     = out_r.illegal;
    assign bus.illegal_cnt = cnt_r;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: a scoreboard queue receives the
// expected decode of every accepted word and is compared on every output
// transfer, plus directed checks of reset, stall, flush and counter behaviour.
module tb_instr_decode_stage;

    localparam logic [5:0] OPC_R    = 6'd0;
    localparam logic [5:0] OPC_ADDI = 6'd1;
    localparam logic [5:0] OPC_SUBI = 6'd2;
    localparam logic [5:0] OPC_ANDI = 6'd3;
    localparam logic [5:0] OPC_ORI  = 6'd4;
    localparam logic [5:0] OPC_XORI = 6'd5;
    localparam logic [5:0] OPC_LUI  = 6'd6;
    localparam logic [5:0] OPC_LLI  = 6'd7;
    localparam logic [5:0] OPC_SWR  = 6'd8;
    localparam logic [5:0] OPC_BAD  = 6'h2A;

    localparam logic [5:0] FN_ADD = 6'd1;
    localparam logic [5:0] FN_SUB = 6'd2;
    localparam logic [5:0] FN_AND = 6'd3;
    localparam logic [5:0] FN_OR  = 6'd4;
    localparam logic [5:0] FN_XOR = 6'd5;
    localparam logic [5:0] FN_SLL = 6'd6;
    localparam logic [5:0] FN_SRL = 6'd7;
    localparam logic [5:0] FN_SLA = 6'd8;
    localparam logic [5:0] FN_SRA = 6'd9;

    typedef struct {
        logic [3:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        rw;
        logic        ui;
        logic        us;
        logic [4:0]  sh;
        logic [31:0] imm;
        logic        st;
        logic        il;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_chk;
    int   n_err;
    logic [3:0] exp_cnt;
    exp_t sb[$];
    exp_t e_mon;
    logic rnd_done;

    instr_decode_stage_if #(.PC_W(32), .CNT_W(4)) bus ();

    instr_decode_stage #(.PC_W(32), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {OPC_R, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference decode written from the instruction-set description.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [5:0] op;
        logic [5:0] f;
        logic [15:0] imm;
        op = w[31:26];
        f = w[5:0];
        imm = w[15:0];
        e.alu = 4'd15; e.rs = w[25:21]; e.rt = w[20:16]; e.sh = w[10:6];
        e.dest = 5'd0; e.rw = 1'b0; e.ui = 1'b0; e.us = 1'b0; e.imm = 32'd0;
        e.st = 1'b0; e.il = 1'b0; e.pc = pc;
        if (w != 32'd0) begin
            if (op == OPC_R) begin
                if (f >= 6'd1 && f <= 6'd9) begin
                    e.alu = 4'(f - 6'd1);
                    e.dest = w[15:11];
                    e.us = (f >= 6'd6);
                end else begin
                    e.il = 1'b1;
                end
            end else if (op >= 6'd1 && op <= 6'd7) begin
                e.ui = 1'b1;
                e.dest = w[20:16];
                case (op)
                    6'd1: begin e.alu = 4'd0;  e.imm = {{16{imm[15]}}, imm}; end
                    6'd2: begin e.alu = 4'd1;  e.imm = {{16{imm[15]}}, imm}; end
                    6'd3: begin e.alu = 4'd2;  e.imm = {16'd0, imm}; end
                    6'd4: begin e.alu = 4'd3;  e.imm = {16'd0, imm}; end
                    6'd5: begin e.alu = 4'd4;  e.imm = {16'd0, imm}; end
                    6'd6: begin e.alu = 4'd9;  e.imm = {imm, 16'd0}; end
                    default: begin e.alu = 4'd10; e.imm = {16'd0, imm}; end
                endcase
            end else if (op == OPC_SWR) begin
                e.alu = 4'd0; e.ui = 1'b1; e.st = 1'b1; e.imm = {{16{imm[15]}}, imm};
            end else begin
                e.il = 1'b1;
            end
        end
        e.rw = !e.il && !e.st && (e.alu != 4'd15) && (e.dest != 5'd0);
        return e;
    endfunction

    // Present one word until accepted; its expected decode joins the scoreboard.
    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        int  waited;
        bit  done;
        waited = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.instruction = w;
        bus.in_pc = pc;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(ref_decode(w, pc));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    check_eq("send_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
        check_eq({tag, "_alu_op"},    32'(bus.alu_op), 32'd15);
        check_eq({tag, "_cnt"},       32'(bus.illegal_cnt), 32'd0);
        check_eq({tag, "_dest"},      32'(bus.dest_reg), 32'd0);
        check_eq({tag, "_imm"},       bus.imm_ext, 32'd0);
        check_eq({tag, "_reg_write"}, 32'(bus.reg_write), 32'd0);
        check_eq({tag, "_pc"},        bus.out_pc, 32'd0);
    endtask

    // Compare every delivered bundle against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check_eq("alu_op",    32'(bus.alu_op),    32'(e_mon.alu));
                check_eq("rs_addr",   32'(bus.rs_addr),   32'(e_mon.rs));
                check_eq("rt_addr",   32'(bus.rt_addr),   32'(e_mon.rt));
                check_eq("dest_reg",  32'(bus.dest_reg),  32'(e_mon.dest));
                check_eq("reg_write", 32'(bus.reg_write), 32'(e_mon.rw));
                check_eq("use_imm",   32'(bus.use_imm),   32'(e_mon.ui));
                check_eq("use_sa",    32'(bus.use_sa),    32'(e_mon.us));
                check_eq("shamt",     32'(bus.shamt),     32'(e_mon.sh));
                check_eq("imm_ext",   bus.imm_ext,        e_mon.imm);
                check_eq("is_store",  32'(bus.is_store),  32'(e_mon.st));
                check_eq("illegal",   32'(bus.illegal),   32'(e_mon.il));
                check_eq("out_pc",    bus.out_pc,         e_mon.pc);
                if (e_mon.il && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            end
        end
    end

    // Overall time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_cnt = 4'd0;
        rnd_done = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.instruction = 32'd0;
        bus.in_pc = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Streaming, one-cycle latency and immediate forms.
        bus.out_ready = 1'b1;
        send(rtype(5'd2, 5'd4, 5'd10, 5'd0, FN_ADD), 32'h100);
        check_eq("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("lat_alu_op",    32'(bus.alu_op), 32'd0);
        check_eq("lat_dest",      32'(bus.dest_reg), 32'd10);
        check_eq("lat_reg_write", 32'(bus.reg_write), 32'd1);
        send(itype(OPC_ADDI, 5'd1, 5'd10, 16'hFFFB), 32'h104);
        check_eq("addi_imm", bus.imm_ext, 32'hFFFF_FFFB);
        send(itype(OPC_ANDI, 5'd1, 5'd10, 16'hFFFB), 32'h108);
        check_eq("andi_imm", bus.imm_ext, 32'h0000_FFFB);
        send(itype(OPC_LUI, 5'd0, 5'd3, 16'h0008), 32'h10C);
        check_eq("lui_imm", bus.imm_ext, 32'h0008_0000);
        send(itype(OPC_SUBI, 5'd5, 5'd6, 16'h8001), 32'h110);
        send(itype(OPC_ORI,  5'd7, 5'd8, 16'h1234), 32'h114);
        send(itype(OPC_XORI, 5'd9, 5'd0, 16'hF0F0), 32'h118);
        send(itype(OPC_LLI,  5'd1, 5'd2, 16'hABCD), 32'h11C);
        send(itype(OPC_SWR,  5'd3, 5'd4, 16'hFFF0), 32'h120);
        check_eq("swr_store", 32'(bus.is_store), 32'd1);
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_SUB), 32'h124);
        send(rtype(5'd4, 5'd5, 5'd6, 5'd0, FN_AND), 32'h128);
        send(rtype(5'd7, 5'd8, 5'd9, 5'd0, FN_OR),  32'h12C);
        send(rtype(5'd10, 5'd11, 5'd12, 5'd0, FN_XOR), 32'h130);
        send(rtype(5'd0, 5'd13, 5'd14, 5'd31, FN_SRL), 32'h134);
        send(rtype(5'd0, 5'd15, 5'd16, 5'd4, FN_SLA), 32'h138);
        send(rtype(5'd0, 5'd17, 5'd18, 5'd7, FN_SRA), 32'h13C);
        send(32'd0, 32'h140);
        check_eq("nop_alu", 32'(bus.alu_op), 32'd15);
        send(rtype(5'd1, 5'd2, 5'd0, 5'd0, FN_ADD), 32'h144);
        check_eq("rd0_reg_write", 32'(bus.reg_write), 32'd0);
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'h148);
        drain("stream_drain");

        // Backpressure: two words fill the stage, the third waits.
        bus.out_ready = 1'b0;
        send(itype(OPC_ADDI, 5'd1, 5'd1, 16'h0001), 32'h200);
        send(itype(OPC_ADDI, 5'd2, 5'd2, 16'h0002), 32'h204);
        check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_hold_pc",  bus.out_pc, 32'h200);
        check_eq("bp_hold_imm", bus.imm_ext, 32'h0000_0001);
        fork
            send(itype(OPC_ADDI, 5'd3, 5'd3, 16'h0003), 32'h208);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Flush while full with a word presented: everything is dropped.
        bus.out_ready = 1'b0;
        send(itype(OPC_ORI, 5'd1, 5'd1, 16'h0011), 32'h300);
        send(itype(OPC_ORI, 5'd2, 5'd2, 16'h0022), 32'h304);
        bus.in_valid = 1'b1;
        bus.instruction = itype(OPC_ORI, 5'd3, 5'd3, 16'h0033);
        bus.in_pc = 32'h308;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_in_ready",  32'(bus.in_ready), 32'd1);
        check_eq("flush_cnt",       32'(bus.illegal_cnt), 32'(exp_cnt));
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("flush_quiet", 32'(bus.out_valid), 32'd0);

        // Random stream with random EX stalls.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [5:0] op;
                    logic [31:0] w;
                    int sel;
                    sel = $urandom_range(0, 9);
                    op = (sel == 9) ? OPC_BAD : 6'(sel);
                    w = $urandom;
                    w[31:26] = op;
                    if (op == OPC_R) w[5:0] = 6'($urandom_range(0, 11));
                    send(w, 32'h400 + 32'(i) * 32'd4);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain("rnd_drain");
        check_eq("rnd_cnt", 32'(bus.illegal_cnt), 32'(exp_cnt));

        // Reset in the middle of a full stage.
        bus.out_ready = 1'b0;
        send(itype(OPC_XORI, 5'd1, 5'd1, 16'h0F0F), 32'h500);
        send(itype(OPC_XORI, 5'd2, 5'd2, 16'hF0F0), 32'h504);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        exp_cnt = 4'd0;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(rtype(5'd0, 5'd30, 5'd7, 5'd2, FN_SLL), 32'h600);
        check_eq("sll_alu",   32'(bus.alu_op), 32'd5);
        check_eq("sll_use_sa", 32'(bus.use_sa), 32'd1);
        check_eq("sll_shamt", 32'(bus.shamt), 32'd2);

        // Illegal opcodes: counting and saturation.
        for (int i = 0; i < 3; i++) begin
            send(itype(OPC_BAD, 5'd1, 5'd2, 16'h0000), 32'h700 + 32'(i) * 32'd4);
            check_eq("illegal_flag", 32'(bus.illegal), 32'd1);
            check_eq("illegal_rw",   32'(bus.reg_write), 32'd0);
        end
        @(posedge clk);
        #1;
        check_eq("illegal_cnt3", 32'(bus.illegal_cnt), 32'd3);
        for (int i = 0; i < 14; i++) begin
            send(itype(OPC_BAD, 5'd3, 5'd4, 16'h1111), 32'h800 + 32'(i) * 32'd4);
        end
        drain("sat_drain");
        check_eq("illegal_cnt_sat", 32'(bus.illegal_cnt), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
